// File: rtl/cpu_pkg.sv
// Shared front-end types: fetch FSM states, redirect causes and default
// program-counter constants.
package cpu_pkg;

  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
  typedef enum logic [1:0] {NONE, BRANCH, TRAP} redir_cause_e;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
  localparam int unsigned DEFAULT_STEP         = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a redirect that arrived while the fetch request was
// stalled. A pending trap cannot be displaced by a later branch.
module pc_redirect_buf
  import cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [XLEN-1:0]   wr_target_i,
  input  redir_cause_e      wr_cause_i,
  input  logic              clr_i,
  output logic              pending_valid_o,
  output logic [XLEN-1:0]   pending_target_o,
  output redir_cause_e      pending_cause_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] target_q, target_d;
  redir_cause_e    cause_q, cause_d;
  logic            wr_blocked;

  always_comb begin
    valid_d    = valid_q;
    target_d   = target_q;
    cause_d    = cause_q;
    wr_blocked = valid_q && (cause_q == TRAP) && (wr_cause_i == BRANCH);
    if (clr_i) begin
      valid_d  = 1'b0;
      target_d = '0;
      cause_d  = NONE;
    end else if (wr_en_i && !wr_blocked) begin
      valid_d  = 1'b1;
      target_d = wr_target_i;
      cause_d  = wr_cause_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
      cause_q  <= NONE;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
      cause_q  <= cause_d;
    end
  end

  assign pending_valid_o  = valid_q;
  assign pending_target_o = target_q;
  assign pending_cause_o  = cause_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential PC, halt/resume, trap/branch redirect
// with stall buffering and misalignment rejection. Perf counters: PC_GEN_PERF_EN.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR[XLEN-1:0],
  parameter int              STEP         = DEFAULT_STEP,
  parameter int              CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vector,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [XLEN-1:0]   fetch_pc,
  output logic              misalign_err,
  output logic [XLEN-1:0]   misalign_addr,
  output logic [CNT_W-1:0]  perf_fetch_cnt,
  output logic [CNT_W-1:0]  perf_redir_cnt
);

  localparam int ALIGN_W = $clog2(STEP);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic            hs;
  logic            trap_ok, redir_ok;
  logic            win_valid;
  logic [XLEN-1:0] win_target;
  redir_cause_e    win_cause;
  logic            buf_wr, buf_clr;
  logic            pend_valid, pend_trap, win_blocked;
  logic [XLEN-1:0] pend_target;
  redir_cause_e    pend_cause;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[ALIGN_W-1:0] == '0;
  endfunction

  assign fetch_valid = (state_q == RUN);
  assign hs          = fetch_valid && fetch_ready;

  // Trap beats branch, but only an aligned trap can win.
  always_comb begin
    trap_ok     = trap_valid && is_aligned(trap_vector);
    redir_ok    = redirect_valid && is_aligned(redirect_target);
    win_valid   = trap_ok || redir_ok;
    win_target  = trap_ok ? trap_vector : redirect_target;
    win_cause   = trap_ok ? TRAP : (redir_ok ? BRANCH : NONE);
    pend_trap   = pend_valid && (pend_cause == TRAP);
    win_blocked = pend_trap && (win_cause == BRANCH);
    mis_d       = 1'b0;
    mis_addr_d  = mis_addr_q;
    if (trap_valid && !is_aligned(trap_vector)) begin
      mis_d      = 1'b1;
      mis_addr_d = trap_vector;
    end else if (redirect_valid && !redir_ok && !trap_ok) begin
      mis_d      = 1'b1;
      mis_addr_d = redirect_target;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_wr  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        buf_wr  = win_valid;
      end
      RUN: begin
        if (hs) begin
          buf_clr = 1'b1;
          if (win_valid && !win_blocked) pc_d = win_target;
          else if (pend_valid)           pc_d = pend_target;
          else                           pc_d = pc_q + XLEN'(STEP);
          if (halt) state_d = HALT;
        end else begin
          buf_wr = win_valid;
        end
      end
      HALT: begin
        if (win_valid) begin
          pc_d    = win_target;
          state_d = RUN;
          buf_clr = 1'b1;
        end else if (!halt) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk              (clk),
    .reset            (reset),
    .wr_en_i          (buf_wr),
    .wr_target_i      (win_target),
    .wr_cause_i       (win_cause),
    .clr_i            (buf_clr),
    .pending_valid_o  (pend_valid),
    .pending_target_o (pend_target),
    .pending_cause_o  (pend_cause)
  );

  assign fetch_pc      = pc_q;
  assign misalign_err  = mis_q;
  assign misalign_addr = mis_addr_q;

`ifdef PC_GEN_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, redir_cnt_q;
  logic             redir_inc;

  // A redirect counts when applied directly or when it lands in the buffer.
  assign redir_inc = (win_valid && (state_q == HALT || (hs && !win_blocked)))
                   || (buf_wr && !win_blocked);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (hs)        fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (redir_inc) redir_cnt_q <= redir_cnt_q + 1'b1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_redir_cnt = redir_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, stalls, redirect/trap priority,
// misalignment, halt/resume, reset mid-stall, and a 16-bit wrap instance.
module tb_pc_gen;

`ifdef PC_GEN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        trap_valid;
  logic [63:0] trap_vector;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic        misalign_err;
  logic [63:0] misalign_addr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_redir_cnt;

  logic        v16;
  logic [15:0] pc16;
  logic        me16;
  logic [15:0] ma16;
  logic [31:0] pf16, pr16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .reset           (reset),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .fetch_pc        (fetch_pc),
    .misalign_err    (misalign_err),
    .misalign_addr   (misalign_addr),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_redir_cnt  (perf_redir_cnt)
  );

  pc_gen #(.XLEN(16), .RESET_VECTOR(16'hFFF8)) dut16 (
    .clk             (clk),
    .reset           (reset),
    .halt            (1'b0),
    .redirect_valid  (1'b0),
    .redirect_target (16'h0),
    .trap_valid      (1'b0),
    .trap_vector     (16'h0),
    .fetch_valid     (v16),
    .fetch_ready     (1'b1),
    .fetch_pc        (pc16),
    .misalign_err    (me16),
    .misalign_addr   (ma16),
    .perf_fetch_cnt  (pf16),
    .perf_redir_cnt  (pr16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_vector = '0;
    step(); step();
    chk("rst_valid", fetch_valid, 0);
    chk("rst_pc", fetch_pc, 64'h0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_mis_addr", misalign_addr, 0);
    chk("rst_fcnt", perf_fetch_cnt, 0);
    chk("rst_rcnt", perf_redir_cnt, 0);

    // Sequential fetch with ready held high
    reset = 1'b0;
    chk("boot_valid", fetch_valid, 0);
    chk("boot_valid16", v16, 0);
    step();
    chk("seq_valid", fetch_valid, 1);
    chk("seq_pc0", fetch_pc, 64'h0);
    chk("w16_pc0", pc16, 16'hFFF8);
    step();
    chk("seq_pc4", fetch_pc, 64'h4);
    chk("w16_pc1", pc16, 16'hFFFC);
    step();
    chk("seq_pc8", fetch_pc, 64'h8);
    chk("w16_wrap", pc16, 16'h0000);
    step();
    chk("seq_pcC", fetch_pc, 64'hC);
    step();
    chk("seq_pc10", fetch_pc, 64'h10);
    chk("seq_fcnt", perf_fetch_cnt, PERF ? 4 : 0);

    // Redirect while stalled
    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 64'h100;
    step();
    redirect_valid = 1'b0;
    chk("stall_pc_a", fetch_pc, 64'h10);
    chk("stall_valid", fetch_valid, 1);
    step();
    chk("stall_pc_b", fetch_pc, 64'h10);
    fetch_ready = 1'b1;
    step();
    chk("redir_pc", fetch_pc, 64'h100);
    step();
    chk("redir_pc_next", fetch_pc, 64'h104);
    chk("redir_rcnt", perf_redir_cnt, PERF ? 1 : 0);
    chk("redir_fcnt", perf_fetch_cnt, PERF ? 6 : 0);

    // Trap and branch together while stalled: trap wins
    fetch_ready = 1'b0;
    trap_valid = 1'b1; trap_vector = 64'h800;
    redirect_valid = 1'b1; redirect_target = 64'h200;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    chk("prio_hold", fetch_pc, 64'h104);
    fetch_ready = 1'b1;
    step();
    chk("prio_pc", fetch_pc, 64'h800);
    chk("prio_rcnt", perf_redir_cnt, PERF ? 2 : 0);

    // Pending trap is not displaced by a later branch
    fetch_ready = 1'b0;
    trap_valid = 1'b1; trap_vector = 64'h900;
    step();
    trap_valid = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'hA00;
    step();
    redirect_valid = 1'b0;
    chk("lock_hold", fetch_pc, 64'h800);
    fetch_ready = 1'b1;
    step();
    chk("lock_pc", fetch_pc, 64'h900);
    step();
    chk("lock_pc_next", fetch_pc, 64'h904);
    chk("lock_rcnt", perf_redir_cnt, PERF ? 3 : 0);

    // Misaligned branch target
    redirect_valid = 1'b1; redirect_target = 64'h102;
    step();
    redirect_valid = 1'b0;
    chk("mis_pc", fetch_pc, 64'h908);
    chk("mis_err", misalign_err, 1);
    chk("mis_addr", misalign_addr, 64'h102);
    step();
    chk("mis_pc_next", fetch_pc, 64'h90C);
    chk("mis_err_drop", misalign_err, 0);
    chk("mis_addr_hold", misalign_addr, 64'h102);
    chk("mis_rcnt", perf_redir_cnt, PERF ? 3 : 0);

    // Misaligned trap with aligned branch on a handshake
    trap_valid = 1'b1; trap_vector = 64'h203;
    redirect_valid = 1'b1; redirect_target = 64'h300;
    step();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    chk("mtrap_pc", fetch_pc, 64'h300);
    chk("mtrap_err", misalign_err, 1);
    chk("mtrap_addr", misalign_addr, 64'h203);
    chk("mtrap_rcnt", perf_redir_cnt, PERF ? 4 : 0);

    // Halt and trap-resume
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(); step(); step(); step(); step();
    chk("h_pc10", fetch_pc, 64'h10);
    halt = 1'b1;
    step();
    chk("h_valid", fetch_valid, 0);
    chk("h_pc", fetch_pc, 64'h14);
    step();
    chk("h_stay", fetch_valid, 0);
    trap_valid = 1'b1; trap_vector = 64'h400;
    step();
    trap_valid = 1'b0; halt = 1'b0;
    chk("h_trap_valid", fetch_valid, 1);
    chk("h_trap_pc", fetch_pc, 64'h400);
    step();
    chk("h_trap_next", fetch_pc, 64'h404);
    halt = 1'b1;
    step();
    chk("h2_valid", fetch_valid, 0);
    halt = 1'b0;
    step();
    chk("resume_valid", fetch_valid, 1);
    chk("resume_pc", fetch_pc, 64'h408);

    // Reset during a stall with a pending redirect
    fetch_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'h500;
    step();
    redirect_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_pc", fetch_pc, 64'h0);
    chk("mrst_valid", fetch_valid, 0);
    chk("mrst_mis_addr", misalign_addr, 0);
    fetch_ready = 1'b1;
    step();
    chk("mrst_pc0", fetch_pc, 64'h0);
    step();
    chk("mrst_no_pend", fetch_pc, 64'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter and fetch-address generator for the CPU front end.
- Issues fetch addresses to instruction memory over a valid/ready handshake.
- Supports halt/resume, branch redirect and trap redirect, with priority arbitration and buffering of redirects that arrive while a request is stalled.
- Detects misaligned targets and sits between the control/branch unit and the instruction-fetch stage.

Parameters:
- XLEN, 64, address width in bits.
- RESET_VECTOR, 64'h0, first fetch address after reset (XLEN bits).
- STEP, 4, sequential increment in bytes; also defines the alignment requirement (target must be a multiple of STEP; STEP is a power of two, at least 2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- halt  input  1  level; enter HALT at the next handshake boundary.
- redirect_valid  input  1  branch/jump taken pulse.
- redirect_target  input  XLEN  branch target.
- trap_valid  input  1  exception/interrupt pulse.
- trap_vector  input  XLEN  trap handler address.
- fetch_valid  output  1  fetch_pc is valid.
- fetch_ready  input  1  instruction memory accepts the request.
- fetch_pc  output  XLEN  current fetch address.
- misalign_err  output  1  one-cycle pulse: rejected misaligned target.
- misalign_addr  output  XLEN  last rejected target (held).
- perf_fetch_cnt  output  CNT_W  accepted fetch count.
- perf_redir_cnt  output  CNT_W  applied redirect/trap count.

Behaviour:
- Reset (synchronous):
  - fetch_pc=RESET_VECTOR, fetch_valid=0, state=BOOT.
  - pending buffer cleared; misalign_err=0, misalign_addr=0.
  - Both counters=0.
  - Reset asserted mid-transaction discards any outstanding request and pending redirect.
- States:
  - BOOT: one cycle with fetch_valid=0, then RUN.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0.
- RUN, on handshake (fetch_valid and fetch_ready):
  - If pending, fetch_pc <= pending_target and pending clears.
  - Else fetch_pc <= fetch_pc+STEP, modulo 2^XLEN; wrap-around is silent.
  - If halt is also high, go to HALT.
- RUN, no handshake:
  - fetch_pc and fetch_valid held stable; valid/ready rule, no retraction.
- Redirect arbitration, same cycle: trap_valid beats redirect_valid. The loser is dropped.
- Applying a winner:
  - If no handshake this cycle, the winner is written to the pending buffer; a later trap overwrites a pending redirect, a later redirect never overwrites a pending trap.
  - If a handshake occurs in the same cycle, the winner becomes fetch_pc next cycle directly.
  - The apply latency is therefore 1 cycle after the next handshake or same-cycle accept.
- HALT:
  - A valid aligned redirect or trap loads fetch_pc directly and returns to RUN next cycle, even if halt is still high; halt must drop before the next handshake or the block re-enters HALT.
  - halt deasserting alone resumes RUN with fetch_pc unchanged.
- Misalignment:
  - A target with any of bits [log2(STEP)-1:0] nonzero is ignored (no pending update, no state change).
  - misalign_err=1 for exactly the following cycle; misalign_addr latches the target.
  - trap_vector is checked the same way.
  - A misaligned trap does not block a simultaneous aligned redirect.
- Counters (see Optional Feature):
  - perf_fetch_cnt increments on each handshake.
  - perf_redir_cnt increments when a redirect/trap enters pending or is directly applied; an overwrite of pending counts again.
  - Counters wrap at 2^CNT_W.

Optional Feature:
- Macro PC_GEN_PERF_EN.
- Defined: perf counters are implemented as described.
- Undefined: no counter registers; perf_fetch_cnt and perf_redir_cnt are constant 0; the ports remain.

Decomposition:
- Shared package cpu_pkg: state enum (BOOT, RUN, HALT), default RESET_VECTOR, STEP constant, and a redirect-cause type (NONE, BRANCH, TRAP) used by pending-buffer logic.
- One natural sub-module, pc_redirect_buf: holds pending_valid, pending_target and pending_cause; implements trap-over-branch overwrite and clear-on-consume.

Test Plan:
- Reset, then fetch_ready=1 constantly: fetch_valid low one cycle, then fetch_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles; perf_fetch_cnt=4.
- fetch_ready=0 at pc 0x8, redirect to 0x100, then ready=1 two cycles later: fetch_pc stays 0x8 until the handshake, then 0x100, 0x104.
- Same cycle trap_valid (0x800) and redirect_valid (0x200), no handshake: next accepted fetch after 0x8 is 0x800; perf_redir_cnt=1.
- redirect_target 0x102 with STEP=4: ignored, misalign_err pulses 1 cycle, misalign_addr=0x102, sequence continues at +4.
- XLEN=16, RESET_VECTOR=16'hFFF8: sequence FFF8, FFFC, 0000.
- halt=1 at pc 0x10 with handshake: fetch_valid=0 next cycle; a trap to 0x400 while halted gives fetch_valid=1, fetch_pc=0x400 one cycle later; reset asserted mid-stall gives fetch_pc=RESET_VECTOR and the pending buffer cleared.
